// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encoding
// used by the datapath, the shift counter control and the bench.
package univ_shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // True for the two modes that move one bit through the register.
  function automatic logic is_shift(input logic [1:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL);
  endfunction

endpackage

// File: rtl/univ_shift_reg_sat_counter.sv
// Saturating up-counter that tracks serial shifts since the last load/reset.
// o_at_max is registered alongside the count so it rises on the same edge
// the count reaches MAX and never glitches from a compare.
module sat_counter #(
  parameter int MAX = 6,
  parameter int CW  = 3
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_count,
  output logic          o_at_max
);

  logic [CW-1:0] r_count;
  logic          r_at_max;

  // Reset and clear restart the word; increments stop at MAX (no wrap).
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count  <= '0;
      r_at_max <= 1'b0;
    end else if (i_clr) begin
      r_count  <= '0;
      r_at_max <= 1'b0;
    end else if (i_inc && (r_count != CW'(MAX))) begin
      r_count  <= r_count + CW'(1);
      r_at_max <= (r_count == CW'(MAX - 1));
    end
  end

  assign o_count  = r_count;
  assign o_at_max = r_at_max;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load,
// with optional rotate. Counts shifts since the last load/reset and flags
// when a full word has passed through.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter  int               WIDTH     = 6,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int               CW        = $clog2(WIDTH + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [1:0]       i_mode,
  input  logic             i_rotate,
  input  logic             i_sir,
  input  logic             i_sil,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sor,
  output logic             o_sol,
  output logic [CW-1:0]    o_count,
  output logic             o_full
);

  logic [WIDTH-1:0] r_q;
  logic             w_right_in;
  logic             w_left_in;
  logic             w_inc;
  logic             w_clr;

  // In rotate mode the bit leaving one end re-enters at the other.
  assign w_right_in = i_rotate ? r_q[0]       : i_sir;
  assign w_left_in  = i_rotate ? r_q[WIDTH-1] : i_sil;

  assign w_inc = is_shift(i_mode);
  assign w_clr = (i_mode == MODE_LOAD);

  // Datapath register; reset wins over every mode.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_q <= RESET_VAL;
    end else begin
      case (mode_e'(i_mode))
        MODE_HOLD: r_q <= r_q;
        MODE_SHR:  r_q <= {w_right_in, r_q[WIDTH-1:1]};
        MODE_SHL:  r_q <= {r_q[WIDTH-2:0], w_left_in};
        MODE_LOAD: r_q <= i_d;
        default:   r_q <= r_q;
      endcase
    end
  end

  sat_counter #(
    .MAX (WIDTH),
    .CW  (CW)
  ) u_shift_cnt (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clr    (w_clr),
    .i_inc    (w_inc),
    .o_count  (o_count),
    .o_at_max (o_full)
  );

  assign o_q   = r_q;
  assign o_sor = r_q[0];
  assign o_sol = r_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=6): directed scenarios plus random
// traffic, checked against an arithmetic reference model via a scoreboard.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  localparam int W  = 6;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic          rotate = 1'b0;
  logic          sir = 1'b0;
  logic          sil = 1'b0;
  logic [W-1:0]  d = '0;
  logic [W-1:0]  q;
  logic          sor;
  logic          sol;
  logic [CW-1:0] count;
  logic          full;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0]  q;
    logic [CW-1:0] c;
    logic          f;
  } exp_t;

  exp_t sb[$];

  int   m_q = 0;
  int   m_c = 0;
  logic last_sor;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL('0)) dut (
    .i_clock  (clk),
    .i_reset  (reset),
    .i_mode   (mode),
    .i_rotate (rotate),
    .i_sir    (sir),
    .i_sil    (sil),
    .i_d      (d),
    .o_q      (q),
    .o_sor    (sor),
    .o_sol    (sol),
    .o_count  (count),
    .o_full   (full)
  );

  always #20 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // One clock of stimulus: drive at negedge, advance the reference model,
  // queue what the DUT must show after the following rising edge.
  task automatic step(input logic rst, input logic [1:0] md, input logic rot,
                      input logic si_r, input logic si_l, input logic [W-1:0] dd);
    int   mask;
    int   bit_in;
    exp_t e;
    mask = (1 << W) - 1;
    @(negedge clk);
    last_sor = sor;
    reset = rst; mode = md; rotate = rot; sir = si_r; sil = si_l; d = dd;
    if (rst) begin
      m_q = 0;
      m_c = 0;
    end else if (md == MODE_LOAD) begin
      m_q = int'(dd);
      m_c = 0;
    end else if (md == MODE_SHR) begin
      bit_in = rot ? (m_q % 2) : int'(si_r);
      m_q = (m_q / 2) + bit_in * (1 << (W - 1));
      m_c = (m_c < W) ? m_c + 1 : W;
    end else if (md == MODE_SHL) begin
      bit_in = rot ? ((m_q >> (W - 1)) % 2) : int'(si_l);
      m_q = ((m_q * 2) & mask) + bit_in;
      m_c = (m_c < W) ? m_c + 1 : W;
    end
    e.q = W'(m_q);
    e.c = CW'(m_c);
    e.f = (m_c == W);
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Look at the DUT right after the edge that applies the last step.
  task automatic expect_state(input string name, input logic [W-1:0] eq,
                              input int ec, input logic ef);
    @(posedge clk);
    #2;
    chk({name, ".q"}, int'(q), int'(eq));
    chk({name, ".count"}, int'(count), ec);
    chk({name, ".full"}, int'(full), int'(ef));
  endtask

  // Monitor: every rising edge that consumes a queued step is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (q !== e.q || count !== e.c || full !== e.f ||
            sor !== e.q[0] || sol !== e.q[W-1]) begin
          errors++;
          $display("FAIL scoreboard: got q=%b cnt=%0d full=%b sor=%b sol=%b expected q=%b cnt=%0d full=%b",
                   q, count, full, sor, sol, e.q, e.c, e.f);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] sir_seq;
    logic [W-1:0] sor_seq;

    // Reset for two edges.
    step(1, MODE_HOLD, 0, 0, 0, '0);
    step(1, MODE_HOLD, 0, 0, 0, '0);
    expect_state("reset", 6'b000000, 0, 0);
    chk("reset.sor", int'(sor), 0);
    chk("reset.sol", int'(sol), 0);

    // SIPO: MSB-first entry of 1,0,0,1,0,1.
    sir_seq = 6'b100101;
    for (int i = 0; i < W; i++) step(0, MODE_SHR, 0, sir_seq[W-1-i], 0, '0);
    expect_state("sipo", 6'b101001, 6, 1);
    step(0, MODE_SHR, 0, 1, 0, '0);
    expect_state("sipo_sat", 6'b110100, 6, 1);

    // Load then PISO; SOR before each edge.
    step(0, MODE_LOAD, 0, 0, 0, 6'b110010);
    expect_state("load", 6'b110010, 0, 0);
    sor_seq = 6'b110010;
    for (int i = 0; i < W; i++) begin
      step(0, MODE_SHR, 0, 0, 0, '0);
      chk($sformatf("piso.sor%0d", i), int'(last_sor), int'(sor_seq[i]));
    end

    // Rotate left.
    step(0, MODE_LOAD, 0, 0, 0, 6'b100001);
    step(0, MODE_SHL, 1, 0, 0, '0);
    expect_state("rotl1", 6'b000011, 1, 0);
    step(0, MODE_SHL, 1, 0, 0, '0);
    expect_state("rotl2", 6'b000110, 2, 0);
    for (int i = 0; i < 4; i++) step(0, MODE_SHL, 1, 0, 0, '0);
    expect_state("rotl6", 6'b100001, 6, 1);

    // Hold, then reset mid-stream.
    step(1, MODE_HOLD, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, MODE_SHR, 0, 1, 0, '0);
    expect_state("shr3", 6'b111000, 3, 0);
    step(0, MODE_HOLD, 1, 0, 1, 6'b010101);
    step(0, MODE_HOLD, 0, 1, 1, 6'b101010);
    expect_state("hold", 6'b111000, 3, 0);
    step(1, MODE_SHR, 0, 1, 1, '0);
    expect_state("midreset", 6'b000000, 0, 0);

    // Reset beats load; load clears Full.
    step(1, MODE_LOAD, 0, 0, 0, 6'b111111);
    expect_state("rst_prio", 6'b000000, 0, 0);
    for (int i = 0; i < W; i++) step(0, MODE_SHL, 0, 0, 1, '0);
    expect_state("fill", 6'b111111, 6, 1);
    step(0, MODE_LOAD, 1, 0, 0, 6'b010110);
    expect_state("load_full", 6'b010110, 0, 0);

    // Random traffic, mixed directions and rotate, occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), W'($urandom));
    end

    @(posedge clk);
    #5;
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
